// File: rtl/wb4_fifo_stream_reader_if.sv
// Signal bundle between the FIFO-draining WB4 read master, the FIFO read port
// and the downstream valid/ready consumer.
interface wb4_fifo_stream_reader_if #(
    parameter int P_DATA_MSB = 7
);
    logic                wb4_mcyc;
    logic                wb4_mstb;
    logic                wb4_mack;
    logic [P_DATA_MSB:0] wb4_mdata;
    logic                wb4_mstall;
    logic                tvalid;
    logic                tready;
    logic [P_DATA_MSB:0] tdata;

    modport master (
        output wb4_mcyc, wb4_mstb, tvalid, tdata,
        input  wb4_mack, wb4_mdata, wb4_mstall, tready
    );

    modport slave (
        input  wb4_mcyc, wb4_mstb, tvalid, tdata,
        output wb4_mack, wb4_mdata, wb4_mstall, tready
    );
endinterface

// File: rtl/wb4_fifo_stream_reader.sv
// Pipelined WB4 read master that drains a FIFO into a response buffer and
// presents the buffered words as a valid/ready stream.
module wb4_fifo_stream_reader #(
    parameter int P_DATA_MSB    = 7,
    parameter int P_BUF_DEPTH   = 4,
    parameter int P_ACK_TIMEOUT = 255
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    wb4_fifo_stream_reader_if.master        bus,
    output logic                            o_busy,
    output logic                            o_err
);
    localparam int PW = $clog2(P_BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (P_ACK_TIMEOUT > 0) ? $clog2(P_ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(P_ACK_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       outst_q, outst_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                err_q, err_d;
    logic [P_DATA_MSB:0] mem_q [P_BUF_DEPTH];

    logic credit_s, cyc_s, stb_s, req_s, ack_ok_s, ack_bad_s, pop_s, tmo_hit_s;

    // Credit counts both in-flight reads and buffered words, so every ack has a free slot.
    assign credit_s  = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW + 1)'(P_BUF_DEPTH);
    assign cyc_s     = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign stb_s     = (state_q == S_ACTIVE) && i_en && credit_s;
    assign req_s     = stb_s && !bus.wb4_mstall;
    assign ack_ok_s  = bus.wb4_mack && (outst_q != {CW{1'b0}});
    assign ack_bad_s = bus.wb4_mack && (outst_q == {CW{1'b0}});
    assign pop_s     = (cnt_q != {CW{1'b0}}) && bus.tready;

    assign bus.wb4_mcyc = cyc_s;
    assign bus.wb4_mstb = stb_s;
    assign bus.tvalid   = (cnt_q != {CW{1'b0}});
    assign bus.tdata    = mem_q[rd_ptr_q];
    assign o_busy       = (state_q != S_IDLE) || (cnt_q != {CW{1'b0}});
    assign o_err        = err_q;

    // Ack watchdog: abort fires on the cycle the counter reaches the limit.
    always_comb begin
        tmo_d     = tmo_q;
        tmo_hit_s = 1'b0;
        if ((state_q == S_ABORT) || (outst_q == {CW{1'b0}}) || bus.wb4_mack) begin
            tmo_d = {TW{1'b0}};
        end else if (cyc_s && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end
        if ((P_ACK_TIMEOUT != 0) && cyc_s && (outst_q != {CW{1'b0}})
            && !bus.wb4_mack && (tmo_d == TMO_MAX)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Bus cycle state machine; DRAIN always returns through IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_en && credit_s) state_d = S_ACTIVE;
                else                  state_d = S_IDLE;
            end
            S_ACTIVE: begin
                if (tmo_hit_s)                                   state_d = S_ABORT;
                else if (!credit_s && outst_q == {CW{1'b0}})     state_d = S_IDLE;
                else if (!i_en || !credit_s)                     state_d = S_DRAIN;
                else                                             state_d = S_ACTIVE;
            end
            S_DRAIN: begin
                if (tmo_hit_s)                                   state_d = S_ABORT;
                else if ((outst_q == {CW{1'b0}})
                         || ((outst_q == CW'(1)) && bus.wb4_mack)) state_d = S_IDLE;
                else                                             state_d = S_DRAIN;
            end
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding-read, buffer occupancy, pointer and error next-state.
    always_comb begin
        outst_d  = outst_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q | ack_bad_s | tmo_hit_s;
        if (tmo_hit_s)                outst_d = {CW{1'b0}};
        else if (req_s && !ack_ok_s)  outst_d = outst_q + CW'(1);
        else if (!req_s && ack_ok_s)  outst_d = outst_q - CW'(1);
        else                          outst_d = outst_q;
        if (ack_ok_s) wr_ptr_d = wr_ptr_q + PW'(1);
        else          wr_ptr_d = wr_ptr_q;
        if (pop_s)    rd_ptr_d = rd_ptr_q + PW'(1);
        else          rd_ptr_d = rd_ptr_q;
        case ({ack_ok_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers and response buffer storage; reset discards buffered data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            outst_q  <= {CW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            tmo_q    <= {TW{1'b0}};
            err_q    <= 1'b0;
            for (int i = 0; i < P_BUF_DEPTH; i++) begin
                mem_q[i] <= {(P_DATA_MSB + 1){1'b0}};
            end
        end else begin
            state_q  <= state_d;
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            if (ack_ok_s) begin
                mem_q[wr_ptr_q] <= bus.wb4_mdata;
            end
        end
    end
endmodule

// File: tb/tb_wb4_fifo_stream_reader.sv
// Directed bench: behavioural WB4 FIFO slave, scoreboard of words written into
// the FIFO, compared in order as the stream delivers them.
module tb_wb4_fifo_stream_reader;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_en = 1'b0;
    logic o_busy, o_err;

    wb4_fifo_stream_reader_if #(.P_DATA_MSB(7)) bus();

    wb4_fifo_stream_reader #(
        .P_DATA_MSB(7), .P_BUF_DEPTH(DEPTH), .P_ACK_TIMEOUT(8)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .bus(bus),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       ack_pend = 1'b0;
    logic [7:0] ack_data = 8'h00;
    logic       drop_acks = 1'b0;
    logic       inject_ack = 1'b0;
    logic       rand_ready = 1'b0;
    logic       tready_val = 1'b1;
    int inflight_tb = 0, buffered_tb = 0;
    int n_acc = 0, n_pop = 0;
    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of the FIFO slave and stream consumer models.
    task automatic tick();
        logic acc, vack, pop;
        @(negedge clk);
        bus.wb4_mstall = (fifo_q.size() == 0);
        bus.wb4_mack   = ack_pend | inject_ack;
        bus.wb4_mdata  = inject_ack ? 8'hEE : ack_data;
        bus.tready     = rand_ready ? ($urandom_range(0, 1) != 0) : tready_val;
        inject_ack     = 1'b0;
        #1;
        if (i_rst) begin
            ack_pend = 1'b0; inflight_tb = 0; buffered_tb = 0;
            fifo_q.delete(); exp_q.delete();
            return;
        end
        chk("tvalid", 32'(bus.tvalid), 32'(buffered_tb != 0));
        acc  = bus.wb4_mstb & ~bus.wb4_mstall;
        vack = bus.wb4_mack & (inflight_tb > 0);
        pop  = bus.tvalid & bus.tready;
        if (pop) begin
            n_pop++;
            chk("stream_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("stream_data", 32'(bus.tdata), 32'(exp_q.pop_front()));
        end
        inflight_tb = inflight_tb + int'(acc) - int'(vack);
        buffered_tb = buffered_tb + int'(vack) - int'(pop);
        if (acc) begin
            n_acc++;
            ack_data = fifo_q.pop_front();
            ack_pend = ~drop_acks;
        end else begin
            ack_pend = 1'b0;
        end
        chk("credit", 32'((inflight_tb + buffered_tb) <= DEPTH), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cyc"},    32'(bus.wb4_mcyc), 32'd0);
        chk({tag, "_stb"},    32'(bus.wb4_mstb), 32'd0);
        chk({tag, "_tvalid"}, 32'(bus.tvalid),   32'd0);
        chk({tag, "_busy"},   32'(o_busy),       32'd0);
        chk({tag, "_err"},    32'(o_err),        32'd0);
        chk({tag, "_tdata"},  32'(bus.tdata),    32'd0);
    endtask

    task automatic push_word(input logic [7:0] w, input logic expect_out);
        fifo_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    initial begin
        int a0, p0, hi;
        bus.wb4_mack = 1'b0; bus.wb4_mdata = 8'h00;
        bus.wb4_mstall = 1'b1; bus.tready = 1'b1;

        // Power-on reset
        repeat (2) tick();
        chk_idle("por");
        i_rst = 1'b0;
        tick();

        // T2 single word
        a0 = n_acc; p0 = n_pop;
        push_word(8'h5A, 1'b1);
        i_en = 1'b1;
        repeat (6) tick();
        chk("t2_accepts", 32'(n_acc - a0), 32'd1);
        chk("t2_delivered", 32'(n_pop - p0), 32'd1);
        i_en = 1'b0;
        repeat (3) tick();
        chk("t2_idle_cyc", 32'(bus.wb4_mcyc), 32'd0);
        chk("t2_idle_busy", 32'(o_busy), 32'd0);

        // T3 backpressure: exactly DEPTH reads issued while the consumer stalls
        a0 = n_acc; p0 = n_pop;
        tready_val = 1'b0;
        for (int i = 1; i <= 10; i++) push_word(8'(i), 1'b1);
        i_en = 1'b1;
        repeat (20) tick();
        chk("t3_reads_capped", 32'(n_acc - a0), 32'd4);
        chk("t3_stb_low", 32'(bus.wb4_mstb), 32'd0);
        chk("t3_head", 32'(bus.tdata), 32'h01);
        tready_val = 1'b1;
        repeat (40) tick();
        chk("t3_delivered", 32'(n_pop - p0), 32'd10);
        chk("t3_exp_empty", 32'(exp_q.size()), 32'd0);
        i_en = 1'b0;
        repeat (4) tick();

        // T4 empty FIFO: strobe held against stall, nothing accepted
        a0 = n_acc; p0 = n_pop;
        i_en = 1'b1;
        repeat (5) tick();
        chk("t4_stb_held", 32'(bus.wb4_mstb), 32'd1);
        chk("t4_stalled", 32'(bus.wb4_mstall), 32'd1);
        chk("t4_no_accept", 32'(n_acc - a0), 32'd0);
        push_word(8'h3C, 1'b1);
        repeat (6) tick();
        chk("t4_one_accept", 32'(n_acc - a0), 32'd1);
        chk("t4_delivered", 32'(n_pop - p0), 32'd1);
        i_en = 1'b0;
        repeat (4) tick();

        // T5 ack timeout
        chk("t5_err_before", 32'(o_err), 32'd0);
        a0 = n_acc; p0 = n_pop;
        push_word(8'h77, 1'b0);
        drop_acks = 1'b1;
        i_en = 1'b1;
        for (int i = 0; i < 10 && n_acc == a0; i++) tick();
        chk("t5_accepted", 32'(n_acc - a0), 32'd1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.wb4_mcyc) hi++;
            else break;
        end
        chk("t5_cyc_cycles", 32'(hi), 32'd8);
        chk("t5_err_set", 32'(o_err), 32'd1);
        chk("t5_stb_low", 32'(bus.wb4_mstb), 32'd0);
        inflight_tb = 0;
        drop_acks = 1'b0;
        i_en = 1'b0;
        repeat (3) tick();
        inject_ack = 1'b1;
        repeat (3) tick();
        chk("t5_err_sticky", 32'(o_err), 32'd1);
        chk("t5_ack_dropped", 32'(n_pop - p0), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd0);

        // T1 reset mid-burst with buffered data
        tready_val = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i), 1'b1);
        i_en = 1'b1;
        repeat (6) tick();
        chk("t1_busy_pre", 32'(o_busy), 32'd1);
        chk("t1_tvalid_pre", 32'(bus.tvalid), 32'd1);
        i_rst = 1'b1;
        repeat (2) tick();
        chk_idle("t1_rst");
        i_rst = 1'b0;
        i_en = 1'b0;
        tready_val = 1'b1;
        repeat (2) tick();
        chk("t1_stays_empty", 32'(bus.tvalid), 32'd0);

        // T6 pointer wrap with random backpressure
        p0 = n_pop;
        rand_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 1; i++) push_word(8'($urandom), 1'b1);
        i_en = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        chk("t6_delivered", 32'(n_pop - p0), 32'(3 * DEPTH + 1));
        chk("t6_exp_empty", 32'(exp_q.size()), 32'd0);
        i_en = 1'b0;
        rand_ready = 1'b0;
        repeat (4) tick();
        chk("t6_idle_busy", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
